// File: rtl/vram_pkg.sv
// ============================================================================
// vram_pkg : shared types and defaults for the dual-port video RAM
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package vram_pkg;
    localparam int VRAM_ADDR_W = 18;
    localparam int VRAM_DATA_W = 8;
    localparam int VRAM_STRIDE = 400;
    localparam int VRAM_DIM_W  = 10;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_FILL  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/vram_rect_addr_gen.sv
// ============================================================================
// vram_rect_addr_gen : row-major rectangle address walker (no multiplier)
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module vram_rect_addr_gen #(
    parameter int ADDR_W = 18,
    parameter int DIM_W  = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] start,
    input  logic [ADDR_W-1:0] step,
    input  logic [DIM_W-1:0]  w,
    input  logic [DIM_W-1:0]  h,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DIM_W-1:0]  row_q, row_d, col_q, col_d, w_q, w_d, h_q, h_d;
    logic [ADDR_W-1:0] nxt_base, nxt_addr;
    logic [DIM_W-1:0]  nxt_row, nxt_col;

    // Registers describe the write currently on the bus; addr/last describe
    // the one that follows it.
    always_comb begin
        if (col_q == w_q - DIM_W'(1)) begin
            nxt_col  = '0;
            nxt_row  = row_q + DIM_W'(1);
            nxt_base = row_base_q + step;
            nxt_addr = row_base_q + step;
        end else begin
            nxt_col  = col_q + DIM_W'(1);
            nxt_row  = row_q;
            nxt_base = row_base_q;
            nxt_addr = addr_q + ADDR_W'(1);
        end
        addr = nxt_addr;
        last = (nxt_col == w_q - DIM_W'(1)) && (nxt_row == h_q - DIM_W'(1));
    end

    always_comb begin
        row_base_d = row_base_q;
        addr_d     = addr_q;
        row_d      = row_q;
        col_d      = col_q;
        w_d        = w_q;
        h_d        = h_q;
        if (load) begin
            row_base_d = start;
            addr_d     = start;
            row_d      = '0;
            col_d      = '0;
            w_d        = w;
            h_d        = h;
        end else if (adv) begin
            row_base_d = nxt_base;
            addr_d     = nxt_addr;
            row_d      = nxt_row;
            col_d      = nxt_col;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_base_q <= '0;
            addr_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            w_q        <= '0;
            h_q        <= '0;
        end else begin
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            row_q      <= row_d;
            col_q      <= col_d;
            w_q        <= w_d;
            h_q        <= h_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/vram_writer.sv
// ============================================================================
// vram_writer : VRAM port-b write engine (single write / rectangle fill)
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module vram_writer
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int STRIDE = VRAM_STRIDE,
    parameter int DIM_W  = VRAM_DIM_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DIM_W-1:0]  cmd_w,
    input  logic [DIM_W-1:0]  cmd_h,
    input  logic              abort,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_d,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE);

    state_t            state_q, state_d;
    logic              vram_we_q, vram_we_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_W-1:0] vram_d_q, vram_d_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              gen_load, gen_adv, gen_last;
    logic [ADDR_W-1:0] gen_addr;
    logic              empty_rect;

    vram_rect_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (gen_load),
        .adv     (gen_adv),
        .start   (cmd_addr),
        .step    (ROW_STEP),
        .w       (cmd_w),
        .h       (cmd_h),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    assign empty_rect = (cmd_w == '0) || (cmd_h == '0);

    always_comb begin
        state_d     = state_q;
        vram_we_d   = 1'b0;
        vram_addr_d = vram_addr_q;
        vram_d_d    = vram_d_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        gen_load    = 1'b0;
        gen_adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (cmd_valid) begin
                    busy_d = 1'b1;
                    if (cmd_op == OP_WRITE) begin
                        state_d     = ST_WRITE;
                        vram_we_d   = 1'b1;
                        vram_addr_d = cmd_addr;
                        vram_d_d    = cmd_data;
                        done_d      = 1'b1;
                    end else begin
                        state_d  = ST_FILL;
                        gen_load = 1'b1;
                        if (empty_rect) begin
                            done_d = 1'b1;
                        end else begin
                            vram_we_d   = 1'b1;
                            vram_addr_d = cmd_addr;
                            vram_d_d    = cmd_data;
                            done_d      = (cmd_w == DIM_W'(1)) && (cmd_h == DIM_W'(1));
                        end
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            ST_FILL: begin
                // done_q marks the write on the bus as the final one.
                if (done_q || abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gen_adv     = 1'b1;
                    vram_we_d   = 1'b1;
                    vram_addr_d = gen_addr;
                    done_d      = gen_last;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            vram_we_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_d_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vram_we_q   <= vram_we_d;
            vram_addr_q <= vram_addr_d;
            vram_d_q    <= vram_d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign vram_we   = vram_we_q;
    assign vram_addr = vram_addr_q;
    assign vram_d    = vram_d_q;
    assign busy      = busy_q;
    // An abort ends the fill on the write already on the bus.
    assign done      = done_q | ((state_q == ST_FILL) && abort);
endmodule

`default_nettype wire

// File: tb/tb_vram_writer.sv
// Self-checking bench for vram_writer: per-cycle frame model plus directed
// literal checks of the observed write sequence.
`default_nettype none

module tb_vram_writer;
    import vram_pkg::*;

    localparam int AW  = 18;
    localparam int DW  = 8;
    localparam int STR = 400;
    localparam int DMW = 10;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_op = 1'b0;
    logic [AW-1:0]  cmd_addr = '0;
    logic [DW-1:0]  cmd_data = '0;
    logic [DMW-1:0] cmd_w = '0;
    logic [DMW-1:0] cmd_h = '0;
    logic           abort;
    logic           abort_dir = 1'b0;
    logic           abort_rand = 1'b0;
    logic           rand_abort_en = 1'b0;
    logic           vram_we;
    logic [AW-1:0]  vram_addr;
    logic [DW-1:0]  vram_d;
    logic           busy;
    logic           done;

    assign abort = abort_dir | abort_rand;

    always #5 clock = ~clock;

    vram_writer #(.ADDR_W(AW), .DATA_W(DW), .STRIDE(STR), .DIM_W(DMW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .abort     (abort),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_d    (vram_d),
        .busy      (busy),
        .done      (done)
    );

    // One frame = what the outputs must show in one busy cycle.
    typedef struct {
        bit            we;
        bit            fill;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            done;
    } frame_t;

    frame_t        q[$];
    frame_t        f;
    int            vectors = 0;
    int            miscompares = 0;
    bit            model_ready = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    logic [AW-1:0] wlog[$];
    int            done_cnt = 0;
    int            busy_cnt = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Expand an accepted command into its frames.
    always @(posedge clock) begin
        if (reset_n && model_ready && cmd_valid) begin
            if (cmd_op == OP_WRITE) begin
                q.push_back('{1'b1, 1'b0, cmd_addr, cmd_data, 1'b1});
            end else if (cmd_w == 0 || cmd_h == 0) begin
                q.push_back('{1'b0, 1'b1, '0, '0, 1'b1});
            end else begin
                for (int r = 0; r < int'(cmd_h); r++)
                    for (int c = 0; c < int'(cmd_w); c++)
                        q.push_back('{1'b1, 1'b1, AW'(int'(cmd_addr) + r * STR + c), cmd_data,
                                      (r == int'(cmd_h) - 1) && (c == int'(cmd_w) - 1)});
            end
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            q.delete();
            model_ready = 1'b0;
            last_addr   = '0;
            last_data   = '0;
            check("rst_we", 32'(vram_we), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_addr", 32'(vram_addr), 32'd0);
            check("rst_d", 32'(vram_d), 32'd0);
        end else begin
            if (vram_we) wlog.push_back(vram_addr);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (q.size() == 0) begin
                model_ready = 1'b1;
                check("idle_we", 32'(vram_we), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_done", 32'(done), 32'd0);
                check("idle_ready", 32'(cmd_ready), 32'd1);
            end else begin
                model_ready = 1'b0;
                f = q.pop_front();
                if (f.fill && abort) begin
                    f.done = 1'b1;
                    q.delete();
                end
                if (f.we) begin
                    last_addr = f.addr;
                    last_data = f.data;
                end
                check("we", 32'(vram_we), 32'(f.we));
                check("busy", 32'(busy), 32'd1);
                check("done", 32'(done), 32'(f.done));
                check("ready", 32'(cmd_ready), 32'd0);
            end
            check("addr", 32'(vram_addr), 32'(last_addr));
            check("data", 32'(vram_d), 32'(last_data));
        end
    end

    always @(posedge clock) begin
        #1;
        abort_rand = rand_abort_en && ($urandom_range(0, 15) == 0);
    end

    task automatic issue(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DMW-1:0] w, input logic [DMW-1:0] h);
        int n = 0;
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_w     = w;
        cmd_h     = h;
        forever begin
            @(posedge clock);
            n++;
            if (model_ready || n >= 3000) break;
        end
        if (n >= 3000) check("accept_timeout", 32'd0, 32'd1);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_data  = DW'($urandom);
        cmd_w     = DMW'($urandom);
        cmd_h     = DMW'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !model_ready) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        if (n >= 3000) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_log(string nm, int base, input logic [AW-1:0] exp[$]);
        check({nm, "_nwrites"}, 32'(wlog.size() - base), 32'(exp.size()));
        foreach (exp[i])
            if (base + i < wlog.size())
                check($sformatf("%s_w%0d", nm, i), 32'(wlog[base + i]), 32'(exp[i]));
    endtask

    initial begin
        int            b, dc, bc;
        logic [AW-1:0] e[$];

        repeat (3) @(posedge clock);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // Single write
        b = wlog.size(); dc = done_cnt; bc = busy_cnt;
        issue(OP_WRITE, 18'h00123, 8'hA5, '0, '0);
        drain();
        e = {18'h00123};
        check_log("single", b, e);
        check("single_done_cnt", 32'(done_cnt - dc), 32'd1);
        check("single_busy_cnt", 32'(busy_cnt - bc), 32'd1);

        // Rectangle 3x2
        b = wlog.size(); dc = done_cnt; bc = busy_cnt;
        issue(OP_FILL, 18'h00010, 8'h0F, 10'd3, 10'd2);
        drain();
        e = {18'h010, 18'h011, 18'h012, 18'h1A0, 18'h1A1, 18'h1A2};
        check_log("rect", b, e);
        check("rect_done_cnt", 32'(done_cnt - dc), 32'd1);
        check("rect_busy_cnt", 32'(busy_cnt - bc), 32'd6);

        // Zero-size fill
        b = wlog.size(); dc = done_cnt; bc = busy_cnt;
        issue(OP_FILL, 18'h00200, 8'h11, 10'd0, 10'd5);
        drain();
        e = {};
        check_log("zero", b, e);
        check("zero_done_cnt", 32'(done_cnt - dc), 32'd1);
        check("zero_busy_cnt", 32'(busy_cnt - bc), 32'd1);

        // Address wrap
        b = wlog.size();
        issue(OP_FILL, 18'h3FFFE, 8'h5A, 10'd4, 10'd1);
        drain();
        e = {18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
        check_log("wrap", b, e);

        // Abort during the 5th write, then a normal single write
        b = wlog.size(); dc = done_cnt;
        issue(OP_FILL, 18'h00400, 8'hC3, 10'd10, 10'd10);
        repeat (4) @(posedge clock);
        #1 abort_dir = 1'b1;
        @(posedge clock);
        #1 abort_dir = 1'b0;
        check("abort_ready_next", 32'(cmd_ready), 32'd1);
        drain();
        e = {18'h400, 18'h401, 18'h402, 18'h403, 18'h404};
        check_log("abort", b, e);
        check("abort_done_cnt", 32'(done_cnt - dc), 32'd1);
        b = wlog.size();
        issue(OP_WRITE, 18'h00055, 8'h3C, '0, '0);
        drain();
        e = {18'h00055};
        check_log("post_abort", b, e);

        // Asynchronous reset during write 3 of a 100-byte fill
        issue(OP_FILL, 18'h01000, 8'h77, 10'd100, 10'd1);
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_we", 32'(vram_we), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1 check("post_reset_ready", 32'(cmd_ready), 32'd1);
        b = wlog.size();
        repeat (5) @(posedge clock);
        e = {};
        check_log("post_reset", b, e);

        // Randomized commands with sporadic aborts
        rand_abort_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom), AW'($urandom), DW'($urandom),
                  DMW'($urandom_range(0, 12)), DMW'($urandom_range(0, 12)));
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end
        drain();
        rand_abort_en = 1'b0;
        repeat (3) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
